vga_fb_arbiter: RTL
===================

// Module: vga_fb_arbiter
// PURPOSE
//  Shares one single-port framebuffer RAM between the VGA scan-out reader and one
//  write client (SHA1 result renderer). Scan-out reads always win; writes are
//  buffered in a small FIFO and drained on cycles with no read (blanking or idle).
//  Sits between the VGA timing/pixel pipeline and the framebuffer BRAM, in the
//  25 MHz pixel clock domain.
// PARAMETERS
//  ADDR_W      17   framebuffer word address width
//  DATA_W      12   pixel width, RGB 4:4:4 ({r,g,b})
//  FIFO_DEPTH  4    write FIFO entries, power of 2, >=2
//  RD_LAT      1    RAM read latency in cycles (mem_en -> mem_rdata), >=1
//  STARVE_LIM  64   consecutive cycles a non-empty FIFO may go un-popped before starve
// PORTS
//  clk         in   1           pixel clock, 25 MHz
//  rst         in   1           asynchronous reset, active-low
//  rd_req      in   1           scan-out read request, one per cycle max
//  rd_addr     in   ADDR_W      scan-out read address, sampled with rd_req
//  rd_valid    out  1           rd_data valid, one pulse per accepted rd_req
//  rd_data     out  DATA_W      returned pixel
//  wr_valid    in   1           write client has a word
//  wr_ready    out  1           FIFO can accept; transfer on wr_valid & wr_ready
//  wr_addr     in   ADDR_W      write address
//  wr_data     in   DATA_W      write pixel
//  mem_en      out  1           RAM enable
//  mem_we      out  1           RAM write enable (only with mem_en)
//  mem_addr    out  ADDR_W      RAM address
//  mem_wdata   out  DATA_W      RAM write data
//  mem_rdata   in   DATA_W      RAM read data, valid RD_LAT cycles after mem_en&!mem_we
//  fifo_level  out  clog2(D)+1  FIFO occupancy 0..FIFO_DEPTH
//  state       out  2           grant state: 00 IDLE, 01 RD, 10 WR
//  starve      out  1           sticky starvation flag
//  starve_clr  in   1           clears starve and the starvation counter
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0 incl. wr_ready; FIFO emptied; read
//    pipeline flushed; state=IDLE. In-flight reads at reset never produce rd_valid.
//    First edge after release: wr_ready=1.
//  - All mem_* outputs, rd_valid, rd_data, wr_ready, state are registered.
//  - Grant per edge: rd_req=1 -> RD (mem_en=1, we=0, addr=rd_addr); else FIFO
//    non-empty -> WR (mem_en=1, we=1, head addr/data, pop); else IDLE (mem_en=0,
//    we=0, addr/wdata hold last value). Grant visible on mem_* the cycle after sampling.
//  - Read latency: rd_req sampled at edge k -> mem_en at k+1 -> rd_valid/rd_data
//    registered at edge k+1+RD_LAT+1 (RD_LAT=1: 3 cycles). Fully pipelined, back-to-back
//    reads return in order, no gaps. Valid tracking: RD_LAT+1 deep shift register.
//  - FIFO: push on wr_valid&wr_ready; wr_ready = !full, computed from next-state
//    level. Push+pop same edge: level unchanged, data order preserved. When full,
//    wr_ready=0 and wr_valid is ignored (no overwrite). Write accepted at edge k into
//    empty FIFO reaches mem port no earlier than cycle after edge k+1.
//  - Pointers wrap modulo FIFO_DEPTH; level never exceeds FIFO_DEPTH or underflows.
//  - Starvation: counter increments each edge with level>0 and no pop, resets on pop
//    or level=0, saturates at STARVE_LIM; reaching STARVE_LIM sets starve (sticky).
//    starve_clr wins over set on the same edge; counter restarts from 0.
//  - No write is ever dropped or reordered; reads are never delayed by writes.
// TESTING
//  1. rd_req=0; push (0x00010,0xF00),(0x00011,0x0F0),(0x00012,0x00F) back-to-back ->
//     three consecutive mem_we cycles, same order/values, level returns to 0.
//  2. RD_LAT=1, RAM model echoes addr[11:0]; rd_req with rd_addr=0x00155 ->
//     mem_en&!mem_we next cycle, rd_valid=1 with rd_data=0x155 exactly 3 cycles later.
//  3. rd_req=1 for 800 cycles, 6 writes offered -> 4 accepted, wr_ready=0, no mem_we,
//     starve=1 after 64 cycles; rd_req drops -> 4 writes drained in 4 cycles, level 0.
//  4. Level=2, push and pop on same edge -> level stays 2, next popped word is old head.
//  5. Level=3 and 2 reads in flight, pulse rst low -> all outputs 0 at once, no
//     rd_valid and no mem_we after release, wr_ready=1 one edge after release.
//  6. starve=1 and FIFO still blocked, starve_clr one cycle -> starve=0, re-sets
//     64 cycles later.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM arbiter between VGA scan-out reads and a buffered write client
//
// Purpose:
//   One single-port framebuffer RAM is shared between the VGA scan-out reader
//   and a single write client. Scan-out reads always take the RAM. Writes are
//   queued in a small FIFO and drained on any cycle without a read request.
//   A sticky flag reports when a non-empty FIFO goes un-drained for too long.
//   Everything runs in the 25 MHz pixel clock domain.
//
// Ports:
//   clk, rst                 pixel clock; asynchronous active-low reset
//   rd_req, rd_addr          scan-out read request and address (at most one per cycle)
//   rd_valid, rd_data        returned pixel, one pulse per accepted read, in order
//   wr_valid, wr_ready,
//   wr_addr, wr_data         write client handshake into the write FIFO
//   mem_en, mem_we,
//   mem_addr, mem_wdata      registered RAM command port
//   mem_rdata                RAM read data, RD_LAT cycles after a read command
//   fifo_level               write FIFO occupancy, 0..FIFO_DEPTH
//   state                    current grant: 00 idle, 01 read, 10 write
//   starve, starve_clr       sticky starvation flag and its clear

module vga_fb_arbiter #(
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 4,
   parameter int RD_LAT     = 1,
   parameter int STARVE_LIM = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rd_req,
   input  logic [ADDR_W-1:0]           rd_addr,
   output logic                        rd_valid,
   output logic [DATA_W-1:0]           rd_data,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [DATA_W-1:0]           wr_data,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [1:0]                  state,
   output logic                        starve,
   input  logic                        starve_clr
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(STARVE_LIM + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10
   } grant_t;

   grant_t grant_q;

   // ---------------------------------------------------------------------
   // Write FIFO
   // ---------------------------------------------------------------------
   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level_nxt;
   logic              push;
   logic              pop;
   logic              fifo_nonempty;

   assign fifo_nonempty = (fifo_level != '0);
   assign push          = wr_valid & wr_ready;
   // A read request on this edge owns the RAM, so the head waits.
   assign pop           = ~rd_req & fifo_nonempty;

   always_comb begin
      level_nxt = fifo_level;
      if (push && !pop) begin
         level_nxt = fifo_level + LVL_W'(1);
      end else if (pop && !push) begin
         level_nxt = fifo_level - LVL_W'(1);
      end
   end

   // Storage carries no reset; only the pointers and level define its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= wr_addr;
         fifo_data[wr_ptr] <= wr_data;
      end
   end

   // Power-of-two depth lets the pointers wrap on natural overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         wr_ready   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         fifo_level <= level_nxt;
         // Registered ready is derived from the post-edge level so the
         // client never pushes into a full FIFO.
         wr_ready   <= (level_nxt != LVL_W'(FIFO_DEPTH));
      end
   end

   // ---------------------------------------------------------------------
   // Grant FSM and registered RAM command port
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_q   <= ST_IDLE;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (rd_req) begin
         grant_q  <= ST_RD;
         mem_en   <= 1'b1;
         mem_we   <= 1'b0;
         mem_addr <= rd_addr;
      end else if (fifo_nonempty) begin
         grant_q   <= ST_WR;
         mem_en    <= 1'b1;
         mem_we    <= 1'b1;
         mem_addr  <= fifo_addr[rd_ptr];
         mem_wdata <= fifo_data[rd_ptr];
      end else begin
         // Address and write data hold to avoid needless toggling on the RAM bus.
         grant_q <= ST_IDLE;
         mem_en  <= 1'b0;
         mem_we  <= 1'b0;
      end
   end

   assign state = grant_q;

   // ---------------------------------------------------------------------
   // Read return pipeline
   // ---------------------------------------------------------------------
   // vld_pipe[0] marks a read command on the RAM port; the mark reaches
   // vld_pipe[RD_LAT] one edge after mem_rdata becomes valid. mem_rdata is
   // first captured into rdata_q to keep the RAM clock-to-out path short,
   // so both the valid mark and the data land on rd_* together.
   logic [RD_LAT:0]   vld_pipe;
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         rdata_q  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[RD_LAT-1:0], mem_en & ~mem_we};
         rdata_q  <= mem_rdata;
         rd_valid <= vld_pipe[RD_LAT];
         if (vld_pipe[RD_LAT]) begin
            rd_data <= rdata_q;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Starvation monitor
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] starve_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
         starve     <= 1'b0;
      end else if (starve_clr) begin
         starve_cnt <= '0;
         starve     <= 1'b0;
      end else if (pop || !fifo_nonempty) begin
         starve_cnt <= '0;
      end else if (starve_cnt != CNT_W'(STARVE_LIM)) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
         if (starve_cnt == CNT_W'(STARVE_LIM - 1)) begin
            starve <= 1'b1;
         end
      end
   end

endmodule
